// File: rtl/stream_pkg.sv
// Shared types and helpers for lane-based stream blocks.
package stream_pkg;

    typedef enum logic {StIdle, StSend} state_e;

    // Widest lane mask the helper below can scan.
    localparam int unsigned MaxLanes = 64;

    function automatic int unsigned lowest_set(input logic [MaxLanes-1:0] mask);
        logic found;
        lowest_set = 0;
        found      = 1'b0;
        for (int unsigned i = 0; i < MaxLanes; i++) begin
            if (mask[i] && !found) begin
                lowest_set = i;
                found      = 1'b1;
            end
        end
    endfunction

endpackage

// File: rtl/stream_downsize_if.sv
// Handshake bundle for stream_downsize: wide input beat side (s_*) and narrow output side (m_*).
interface stream_downsize_if #(
    parameter int unsigned T_DATA_WIDTH = 4,
    parameter int unsigned T_DATA_RATIO = 2
);
    logic [T_DATA_WIDTH-1:0] s_data_i [T_DATA_RATIO];
    logic [T_DATA_RATIO-1:0] s_keep_i;
    logic                    s_last_i;
    logic                    s_valid_i;
    logic                    s_ready_o;
    logic [T_DATA_WIDTH-1:0] m_data_o;
    logic                    m_last_o;
    logic                    m_valid_o;
    logic                    m_ready_i;

    // slave: the converter itself; master: the source/consumer environment around it.
    modport slave (
        input  s_data_i, s_keep_i, s_last_i, s_valid_i, m_ready_i,
        output s_ready_o, m_data_o, m_last_o, m_valid_o
    );
    modport master (
        output s_data_i, s_keep_i, s_last_i, s_valid_i, m_ready_i,
        input  s_ready_o, m_data_o, m_last_o, m_valid_o
    );
endinterface

// File: rtl/stream_lane_pick.sv
// Priority encoder over a remaining-lane mask: lowest set lane and whether it is the only one.
module stream_lane_pick
    import stream_pkg::*;
#(
    parameter int unsigned Ratio = 2,
    localparam int unsigned IdxW = $clog2(Ratio)
) (
    input  logic [Ratio-1:0] rem_i,
    output logic [IdxW-1:0]  idx_o,
    output logic             last_lane_o
);
    logic [MaxLanes-1:0] mask_ext;

    always_comb begin
        mask_ext    = MaxLanes'(rem_i);
        idx_o       = IdxW'(lowest_set(mask_ext));
        last_lane_o = $onehot(rem_i);
    end
endmodule

// File: rtl/stream_downsize.sv
// Wide-to-narrow stream converter: emits kept lanes of each beat lowest index first.
// Optional STREAM_DOWNSIZE_BYPASS_EN loads the next beat on the final word's handshake.
module stream_downsize
    import stream_pkg::*;
#(
    parameter int unsigned T_DATA_WIDTH = 4,
    parameter int unsigned T_DATA_RATIO = 2
) (
    input logic              clk,
    input logic              rst_n,
    stream_downsize_if.slave bus
);
    localparam int unsigned IdxW = $clog2(T_DATA_RATIO);

    state_e                  state_q, state_d;
    logic [T_DATA_WIDTH-1:0] data_q [T_DATA_RATIO];
    logic [T_DATA_WIDTH-1:0] data_d [T_DATA_RATIO];
    logic [T_DATA_RATIO-1:0] rem_q, rem_d;
    logic                    last_q, last_d;

    logic [IdxW-1:0] idx;
    logic            last_lane;
    logic            sending;
    logic            s_ready;
    logic            load;

    stream_lane_pick #(
        .Ratio (T_DATA_RATIO)
    ) u_lane_pick (
        .rem_i       (rem_q),
        .idx_o       (idx),
        .last_lane_o (last_lane)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            data_q  <= '{default: '0};
            rem_q   <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            rem_q   <= rem_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        rem_d   = rem_q;
        last_d  = last_q;
        sending = (state_q == StSend);
        s_ready = (state_q == StIdle);
`ifdef STREAM_DOWNSIZE_BYPASS_EN
        s_ready = s_ready | (sending & last_lane & bus.m_ready_i);
`endif
        load = bus.s_valid_i & s_ready;

        unique case (state_q)
            StIdle: ;
            StSend: begin
                if (bus.m_ready_i) begin
                    rem_d[idx] = 1'b0;
                    if (last_lane) state_d = StIdle;
                end
            end
        endcase

        // A load only occurs where the FSM would otherwise sit in IDLE, so it simply overrides.
        if (load) begin
            data_d  = bus.s_data_i;
            rem_d   = bus.s_keep_i;
            last_d  = bus.s_last_i;
            state_d = (|bus.s_keep_i) ? StSend : StIdle;
        end
    end

    assign bus.s_ready_o = s_ready;
    assign bus.m_valid_o = sending;
    assign bus.m_data_o  = sending ? data_q[idx] : '0;
    assign bus.m_last_o  = sending & last_q & last_lane;
endmodule

// File: tb/tb_stream_downsize.sv
// Self-checking bench for stream_downsize: directed scenarios plus a random phase scored against
// a queue model of kept lanes.
module tb_stream_downsize;
    localparam int unsigned W  = 4;
    localparam int unsigned R  = 4;
    localparam int unsigned DW = W * R;
`ifdef STREAM_DOWNSIZE_BYPASS_EN
    localparam int GapCycles = 1;
`else
    localparam int GapCycles = 2;
`endif

    typedef struct packed {
        logic [W-1:0] data;
        logic         last;
    } word_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    stream_downsize_if #(.T_DATA_WIDTH(W), .T_DATA_RATIO(R)) bus ();

    stream_downsize #(
        .T_DATA_WIDTH (W),
        .T_DATA_RATIO (R)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int    passed = 0;
    int    total  = 0;
    int    cyc    = 0;
    word_t exp_q[$];
    int    mhs_cyc[$];
    bit    rand_ready = 1'b0;
    logic  ready_val  = 1'b1;
    logic  stall_q    = 1'b0;
    word_t held;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        #1;
        bus.m_ready_i = rand_ready ? 1'($urandom_range(0, 1)) : ready_val;
    end

    // Reference model: each accepted beat contributes its kept lanes in index order; packet end
    // lands on the highest kept lane. Outputs are scored when a word handshake is seen.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            stall_q = 1'b0;
        end else begin
            if (stall_q) begin
                chk("hold_valid", 32'(bus.m_valid_o), 1);
                chk("hold_data", 32'(bus.m_data_o), 32'(held.data));
                chk("hold_last", 32'(bus.m_last_o), 32'(held.last));
            end
            if (bus.m_valid_o && bus.m_ready_i) begin
                chk("word_expected", 32'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    chk("word_data", 32'(bus.m_data_o), 32'(exp_q[0].data));
                    chk("word_last", 32'(bus.m_last_o), 32'(exp_q[0].last));
                    void'(exp_q.pop_front());
                end
                mhs_cyc.push_back(cyc);
            end
            if (bus.s_valid_i && bus.s_ready_o) begin
                int    hi;
                word_t w;
                hi = -1;
                for (int i = 0; i < int'(R); i++) if (bus.s_keep_i[i]) hi = i;
                for (int i = 0; i < int'(R); i++) begin
                    if (bus.s_keep_i[i]) begin
                        w.data = bus.s_data_i[i];
                        w.last = bus.s_last_i && (i == hi);
                        exp_q.push_back(w);
                    end
                end
            end
            stall_q   = bus.m_valid_o && !bus.m_ready_i;
            held.data = bus.m_data_o;
            held.last = bus.m_last_o;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ready(input bit rnd, input logic v);
        @(negedge clk);
        rand_ready = rnd;
        ready_val  = v;
        step();
    endtask

    // Present one beat, hold it until accepted, then check first-word latency.
    task automatic send(input logic [DW-1:0] dpk, input logic [R-1:0] k, input logic l);
        bit acc;
        int n;
        for (int i = 0; i < int'(R); i++) bus.s_data_i[i] = dpk[i*W +: W];
        bus.s_keep_i  = k;
        bus.s_last_i  = l;
        bus.s_valid_i = 1'b1;
        acc = 1'b0;
        n   = 0;
        while (!acc && n < 100) begin
            @(negedge clk);
            acc = bus.s_ready_o;
            step();
            n++;
        end
        chk("beat_accepted", 32'(acc), 1);
        bus.s_valid_i = 1'b0;
        chk("first_word_latency", 32'(bus.m_valid_o), 32'(|k));
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || bus.m_valid_o) && n < 500) begin
            step();
            n++;
        end
        chk("drain_queue", 32'(exp_q.size()), 0);
        chk("drain_valid", 32'(bus.m_valid_o), 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
        $fatal(1);
    end

    initial begin
        int base;
        bus.s_valid_i = 1'b0;
        bus.s_keep_i  = '0;
        bus.s_last_i  = 1'b0;
        for (int i = 0; i < int'(R); i++) bus.s_data_i[i] = '0;

        repeat (3) step();
        chk("rst_s_ready", 32'(bus.s_ready_o), 1);
        chk("rst_m_valid", 32'(bus.m_valid_o), 0);
        chk("rst_m_last", 32'(bus.m_last_o), 0);
        chk("rst_m_data", 32'(bus.m_data_o), 0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("idle_s_ready", 32'(bus.s_ready_o), 1);
        chk("idle_m_valid", 32'(bus.m_valid_o), 0);

        // Full beat, one word per cycle, last only on D.
        send(16'hDCBA, 4'b1111, 1'b1);
        for (int i = 0; i < 4; i++) begin
            chk("t1_valid", 32'(bus.m_valid_o), 1);
            chk("t1_data", 32'(bus.m_data_o), 32'(4'hA + 4'(i)));
            chk("t1_last", 32'(bus.m_last_o), 32'(i == 3));
            step();
        end
        chk("t1_done_valid", 32'(bus.m_valid_o), 0);
        chk("t1_done_ready", 32'(bus.s_ready_o), 1);

        // Sparse keep: lanes 1 and 3 only.
        send(16'hC5A7, 4'b1010, 1'b0);
        chk("t2_data0", 32'(bus.m_data_o), 32'hA);
        step();
        chk("t2_data1", 32'(bus.m_data_o), 32'hC);
        chk("t2_last1", 32'(bus.m_last_o), 0);
        step();
        chk("t2_done", 32'(bus.m_valid_o), 0);

        // Zero-keep beat is dropped, then a single-lane last beat.
        send(16'h1234, 4'b0000, 1'b0);
        chk("t3_drop_ready", 32'(bus.s_ready_o), 1);
        send(16'h000A, 4'b0001, 1'b1);
        chk("t3_data", 32'(bus.m_data_o), 32'hA);
        chk("t3_last", 32'(bus.m_last_o), 1);
        step();
        chk("t3_done", 32'(bus.m_valid_o), 0);

        // Output stall holds the word and blocks input.
        set_ready(1'b0, 1'b0);
        send(16'h00BA, 4'b0011, 1'b0);
        repeat (5) begin
            chk("t4_valid", 32'(bus.m_valid_o), 1);
            chk("t4_data", 32'(bus.m_data_o), 32'hA);
            chk("t4_s_ready", 32'(bus.s_ready_o), 0);
            step();
        end
        set_ready(1'b0, 1'b1);
        chk("t4_resume_a", 32'(bus.m_data_o), 32'hA);
        step();
        chk("t4_resume_b", 32'(bus.m_data_o), 32'hB);
        step();
        wait_idle();

        // Back-to-back beats: spacing between last word of beat 1 and first of beat 2.
        base = mhs_cyc.size();
        send(16'h0021, 4'b0011, 1'b0);
        send(16'h0043, 4'b0011, 1'b1);
        wait_idle();
        chk("t5_words", 32'(mhs_cyc.size() - base), 4);
        if (mhs_cyc.size() >= base + 3)
            chk("t5_gap", 32'(mhs_cyc[base+2] - mhs_cyc[base+1]), 32'(GapCycles));

        // Reset after the first of three words discards the rest.
        send(16'h0321, 4'b0111, 1'b1);
        step();
        rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", 32'(bus.m_valid_o), 0);
        chk("t6_rst_last", 32'(bus.m_last_o), 0);
        base = mhs_cyc.size();
        repeat (2) step();
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("t6_s_ready", 32'(bus.s_ready_o), 1);
        repeat (3) begin
            chk("t6_no_valid", 32'(bus.m_valid_o), 0);
            step();
        end
        chk("t6_no_words", 32'(mhs_cyc.size() - base), 0);

        // Random beats against random backpressure.
        set_ready(1'b1, 1'b1);
        for (int b = 0; b < 40; b++) begin
            logic [R-1:0] k;
            logic         l;
            k = R'($urandom_range(0, 15));
            l = (k != 0) && ($urandom_range(0, 1) == 1);
            send(DW'($urandom), k, l);
            repeat ($urandom_range(0, 2)) step();
        end
        set_ready(1'b0, 1'b1);
        wait_idle();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
